ddr3_sample_reader: RTL

Read-side streamer between the MIG 7-series user interface and the audio playback path. Issues sequential read commands to DDR3, buffers the returned 256-bit words under a credit scheme (MIG read data cannot be back-pressured), and serializes each word into 16-bit samples on a valid/ready stream for the sound generator. Runs entirely in the MIG `ui_clk` domain.

---
 rtl/ddr_audio_pkg.sv | 18 +
 rtl/rd_word_fifo.sv | 48 ++++
 rtl/ddr3_sample_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ddr_audio_pkg.sv
// Shared constants and types for the DDR3 audio streaming blocks.
package ddr_audio_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int DATA_W_DFLT   = 256;
    localparam int SAMPLE_W_DFLT = 16;
    localparam int LANES         = DATA_W_DFLT / SAMPLE_W_DFLT;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CAL,
        ISSUE,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/rd_word_fifo.sv
// Synchronous word FIFO with occupancy count and synchronous flush.
module rd_word_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_wr, do_rd;

    assign full    = (count == (PW+1)'(DEPTH));
    assign do_rd   = rd_en && (count != '0);
    // A read in the same cycle frees the slot, so writing while full is legal then.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) assert (!(wr_en && full && !do_rd));
    end

endmodule

// File: rtl/ddr3_sample_reader.sv
// Streams sequential DDR3 reads through a credit-limited word FIFO and
// serializes each word into samples, lane 0 (LSBs) first.
module ddr3_sample_reader
    import ddr_audio_pkg::*;
#(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int SAMPLE_W   = SAMPLE_W_DFLT,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 8
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic                init_calib_complete,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         num_words,
    input  logic                loop_en,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output rd_state_t           dbg_state
);
    localparam int NLANES = DATA_W / SAMPLE_W;
    localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CRW    = $clog2(FIFO_DEPTH + 2) + 1;

    rd_state_t         state_q, state_d;
    logic              done_q, done_d, aborting_q, loop_q;
    logic [ADDR_W-1:0] base_q, addr_q;
    logic [15:0]       num_q, issued_q;
    logic [CRW-1:0]    outst_q, credit_sum;
    logic [FCW-1:0]    fifo_count;
    logic [DATA_W-1:0] fifo_rd_data, ser_word_q;
    logic [LW-1:0]     lane_q;
    logic              ser_loaded_q;
    logic              start_ok, stop_hit, cmd_accept, last_cmd, ret_ok;
    logic              fifo_wr, fifo_rd, ser_adv, ser_last;

    // Both streams transfer on a cycle where valid and ready are high together;
    // once valid is raised, its payload is held until that transfer happens.
    assign start_ok   = (state_q == IDLE) && start && !stop && !done_q;
    assign stop_hit   = stop && (state_q != IDLE);
    assign credit_sum = outst_q + CRW'(fifo_count) + CRW'(ser_loaded_q);
    assign app_en     = (state_q == ISSUE) && (credit_sum < CRW'(FIFO_DEPTH + 1));
    assign app_cmd    = CMD_READ;
    assign app_addr   = addr_q;
    assign cmd_accept = app_en && app_rdy;
    assign last_cmd   = (issued_q == num_q - 16'd1);
    // Returns with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign ret_ok     = app_rd_data_valid && (outst_q != '0);
    assign fifo_wr    = ret_ok && !aborting_q && !stop_hit;
    assign ser_adv    = ser_loaded_q && sample_ready;
    assign ser_last   = (lane_q == LW'(NLANES - 1));
    assign fifo_rd    = (fifo_count != '0) && !aborting_q &&
                        (!ser_loaded_q || (ser_adv && ser_last));

    assign sample_valid = ser_loaded_q;
    assign sample_data  = ser_word_q[SAMPLE_W-1:0];
    assign busy         = (state_q != IDLE) || done_q;
    assign done         = done_q;
    assign dbg_state    = state_q;

    rd_word_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (ui_clk),
        .rst     (ui_clk_sync_rst),
        .flush   (stop_hit),
        .wr_en   (fifo_wr),
        .wr_data (app_rd_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (num_words == 16'd0) done_d = 1'b1;
                    else                    state_d = WAIT_CAL;
                end
            end
            WAIT_CAL: if (init_calib_complete) state_d = ISSUE;
            ISSUE:    if (cmd_accept && last_cmd && !loop_q) state_d = DRAIN;
            DRAIN: begin
                if (outst_q == '0 && (aborting_q || (fifo_count == '0 && !ser_loaded_q))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop_hit) begin
            state_d = DRAIN;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            aborting_q   <= 1'b0;
            base_q       <= '0;
            num_q        <= '0;
            loop_q       <= 1'b0;
            addr_q       <= '0;
            issued_q     <= '0;
            outst_q      <= '0;
            ser_word_q   <= '0;
            lane_q       <= '0;
            ser_loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            if (stop_hit)               aborting_q <= 1'b1;
            else if (state_d == IDLE)   aborting_q <= 1'b0;

            if (start_ok) begin
                base_q   <= base_addr;
                num_q    <= num_words;
                loop_q   <= loop_en;
                addr_q   <= base_addr;
                issued_q <= '0;
            end else if (cmd_accept) begin
                if (last_cmd) begin
                    issued_q <= '0;
                    addr_q   <= loop_q ? base_q : addr_q + ADDR_W'(ADDR_STEP);
                end else begin
                    issued_q <= issued_q + 16'd1;
                    addr_q   <= addr_q + ADDR_W'(ADDR_STEP);
                end
            end

            case ({cmd_accept, ret_ok})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: ;
            endcase

            if (stop_hit || aborting_q) begin
                ser_loaded_q <= 1'b0;
                lane_q       <= '0;
            end else if (fifo_rd) begin
                ser_word_q   <= fifo_rd_data;
                lane_q       <= '0;
                ser_loaded_q <= 1'b1;
            end else if (ser_adv) begin
                if (ser_last) begin
                    ser_loaded_q <= 1'b0;
                    lane_q       <= '0;
                end else begin
                    ser_word_q <= ser_word_q >> SAMPLE_W;
                    lane_q     <= lane_q + 1'b1;
                end
            end
        end
    end

endmodule
